// File: rtl/prog_seq_pkg.sv
// Shared opcode encodings and default sizing for the program sequencer.
package prog_seq_pkg;

  localparam int PC_W_DEF        = 12;
  localparam int STACK_DEPTH_DEF = 4;
  localparam int INT_VECTOR_DEF  = 'h004;

  localparam logic [2:0] OP_SEQ    = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_CALL   = 3'b010;
  localparam logic [2:0] OP_RET    = 3'b011;
  localparam logic [2:0] OP_PUSH   = 3'b100;
  localparam logic [2:0] OP_POP    = 3'b101;

  // Reserved encodings 110/111 behave exactly like SEQ.
  function automatic logic is_seq_class(input logic [2:0] op);
    return (op == OP_SEQ) || (op[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/program_sequencer_hw_stack.sv
// Shift-register return stack: push shifts down, pop shifts up and the bottom
// entry duplicates. Overflow drops the oldest entry; underflow still shifts.
module hw_stack #(
  parameter int W     = 12,
  parameter int DEPTH = 4,
  parameter int DW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [DW-1:0] depth,
  output logic          ovf_evt,
  output logic          unf_evt
);

  logic [W-1:0]  stk_q [DEPTH];
  logic [DW-1:0] depth_q;

  assign top     = stk_q[0];
  assign depth   = depth_q;
  assign ovf_evt = push && (depth_q == DW'(DEPTH));
  assign unf_evt = pop && (depth_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      depth_q <= '0;
    end else if (push) begin
      stk_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stk_q[i] <= stk_q[i-1];
      if (!ovf_evt) depth_q <= depth_q + DW'(1);
    end else if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
      if (!unf_evt) depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program counter and return-stack control. Optional interrupt entry is built
// only when PROG_SEQ_INT_EN is defined.
module program_sequencer
  import prog_seq_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter int              PC_STEP     = 2,
  parameter int              STACK_DEPTH = STACK_DEPTH_DEF,
  parameter logic [PC_W-1:0] INT_VECTOR  = PC_W'(INT_VECTOR_DEF)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic [2:0]      op,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] push_data,
  input  logic            clr_flags,
  input  logic            int_req,
  input  logic            eint,
  input  logic            dint,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] stack_top,
  output logic [2:0]      stack_depth,
  output logic            stk_ovf,
  output logic            stk_unf
);

  logic [PC_W-1:0] pc_q, pc_d, seq, tgt, stk_din, stk_top;
  logic            stk_push, stk_pop, ovf_evt, unf_evt, take_int;
  logic            ovf_q, unf_q;

`ifdef PROG_SEQ_INT_EN
  logic pend_q, ien_q;

  assign take_int = !stall && pend_q && ien_q && is_seq_class(op);

  // Pending keeps latching under stall; the enable flag is frozen with the rest.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      ien_q  <= 1'b0;
    end else begin
      pend_q <= int_req | (pend_q & ~take_int);
      if (!stall) begin
        if (dint || take_int) ien_q <= 1'b0;
        else if (eint)        ien_q <= 1'b1;
      end
    end
  end
`else
  logic unused_int_inputs;
  assign unused_int_inputs = ^{int_req, eint, dint};
  assign take_int = 1'b0;
`endif

  always_comb begin
    seq = pc_q + PC_W'(PC_STEP);
    tgt = target;
    if (PC_STEP == 2) tgt[0] = 1'b0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = seq;
    pc_d     = pc_q;
    if (!stall) begin
      if (take_int) begin
        stk_push = 1'b1;
        pc_d     = INT_VECTOR;
      end else begin
        case (op)
          OP_BRANCH: pc_d = cond ? tgt : seq;
          OP_CALL: begin
            stk_push = 1'b1;
            pc_d     = tgt;
          end
          // Underflowing RET still jumps to whatever the top holds.
          OP_RET: begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
          OP_PUSH: begin
            stk_push = 1'b1;
            stk_din  = push_data;
            pc_d     = seq;
          end
          OP_POP: begin
            stk_pop = 1'b1;
            pc_d    = seq;
          end
          default: pc_d = seq;
        endcase
      end
    end
  end

  hw_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH),
    .DW    (3)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (stk_din),
    .top     (stk_top),
    .depth   (stack_depth),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // A new error event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!stall) begin
      pc_q  <= pc_d;
      ovf_q <= ovf_evt | (ovf_q & ~clr_flags);
      unf_q <= unf_evt | (unf_q & ~clr_flags);
    end
  end

  assign pc        = pc_q;
  assign stack_top = stk_top;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: driver queues hand-computed expected
// state per op, a negedge monitor pops and compares.
module tb_program_sequencer;

  localparam int W = 29;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        cond = 1'b0;
  logic [11:0] target = '0;
  logic [11:0] push_data = '0;
  logic        clr_flags = 1'b0;
  logic        int_req = 1'b0;
  logic        eint = 1'b0;
  logic        dint = 1'b0;
  logic [11:0] pc, stack_top;
  logic [2:0]  stack_depth;
  logic        stk_ovf, stk_unf;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           step_n = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  program_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .op          (op),
    .cond        (cond),
    .target      (target),
    .push_data   (push_data),
    .clr_flags   (clr_flags),
    .int_req     (int_req),
    .eint        (eint),
    .dint        (dint),
    .pc          (pc),
    .stack_top   (stack_top),
    .stack_depth (stack_depth),
    .stk_ovf     (stk_ovf),
    .stk_unf     (stk_unf)
  );

  // driver: apply one op for one edge and queue the state expected after it
  task automatic op_t(input logic [2:0] o, input logic c, input logic [11:0] t,
                      input logic [11:0] pd, input logic st, input logic clr,
                      input logic rn, input logic ir, input logic ei,
                      input logic [11:0] e_pc, input logic [11:0] e_top,
                      input logic [2:0] e_d, input logic e_ovf, input logic e_unf);
    op = o; cond = c; target = t; push_data = pd; stall = st;
    clr_flags = clr; reset_n = rn; int_req = ir; eint = ei;
    @(posedge clk);
    exp_q.push_back({e_pc, e_top, e_d, e_ovf, e_unf});
    id_q.push_back(step_n);
    step_n++;
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      int           id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = {pc, stack_top, stack_depth, stk_ovf, stk_unf};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL step%0d {pc,top,depth,ovf,unf}: got %h/%h/%0d/%b/%b exp %h/%h/%0d/%b/%b",
                 id, a[28:17], a[16:5], a[4:2], a[1], a[0],
                 e[28:17], e[16:5], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    // reset overrides a CALL in the same cycle
    op_t(3'b010, 0, 12'h200, 12'h000, 0, 0, 0, 0, 0, 12'h000, 12'h000, 3'd0, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h002, 12'h000, 3'd0, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h004, 12'h000, 3'd0, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h006, 12'h000, 3'd0, 0, 0);
    // stall ignores op
    op_t(3'b001, 1, 12'h100, 12'h000, 1, 0, 1, 0, 0, 12'h006, 12'h000, 3'd0, 0, 0);
    op_t(3'b010, 0, 12'h200, 12'h000, 1, 0, 1, 0, 0, 12'h006, 12'h000, 3'd0, 0, 0);
    // branch with target bit0 masked, then wrap
    op_t(3'b001, 1, 12'hFFF, 12'h000, 0, 0, 1, 0, 0, 12'hFFE, 12'h000, 3'd0, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h000, 12'h000, 3'd0, 0, 0);
    op_t(3'b001, 0, 12'h300, 12'h000, 0, 0, 1, 0, 0, 12'h002, 12'h000, 3'd0, 0, 0);
    op_t(3'b001, 1, 12'h010, 12'h000, 0, 0, 1, 0, 0, 12'h010, 12'h000, 3'd0, 0, 0);
    // call / return
    op_t(3'b010, 0, 12'h200, 12'h000, 0, 0, 1, 0, 0, 12'h200, 12'h012, 3'd1, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h202, 12'h012, 3'd1, 0, 0);
    op_t(3'b011, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h012, 12'h000, 3'd0, 0, 0);
    op_t(3'b110, 1, 12'h500, 12'h000, 0, 0, 1, 0, 0, 12'h014, 12'h000, 3'd0, 0, 0);
    // push 1..5: overflow on the fifth
    op_t(3'b100, 0, 12'h000, 12'h001, 0, 0, 1, 0, 0, 12'h016, 12'h001, 3'd1, 0, 0);
    op_t(3'b100, 0, 12'h000, 12'h002, 0, 0, 1, 0, 0, 12'h018, 12'h002, 3'd2, 0, 0);
    op_t(3'b100, 0, 12'h000, 12'h003, 0, 0, 1, 0, 0, 12'h01A, 12'h003, 3'd3, 0, 0);
    op_t(3'b100, 0, 12'h000, 12'h004, 0, 0, 1, 0, 0, 12'h01C, 12'h004, 3'd4, 0, 0);
    op_t(3'b100, 0, 12'h000, 12'h005, 0, 0, 1, 0, 0, 12'h01E, 12'h005, 3'd4, 1, 0);
    // pop x5: tops seen before each pop are 5,4,3,2,2
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h020, 12'h004, 3'd3, 1, 0);
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h022, 12'h003, 3'd2, 1, 0);
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h024, 12'h002, 3'd1, 1, 0);
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h026, 12'h002, 3'd0, 1, 0);
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h028, 12'h002, 3'd0, 1, 1);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 1, 1, 0, 0, 12'h02A, 12'h002, 3'd0, 0, 0);
    // underflow coinciding with clear: set wins
    op_t(3'b101, 0, 12'h000, 12'h000, 0, 1, 1, 0, 0, 12'h02C, 12'h002, 3'd0, 0, 1);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 1, 1, 0, 0, 12'h02E, 12'h002, 3'd0, 0, 0);
    // RET on empty stack jumps to the current top
    op_t(3'b011, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h002, 12'h002, 3'd0, 0, 1);
    // reset under stall
    op_t(3'b010, 0, 12'h300, 12'h000, 1, 0, 0, 0, 0, 12'h000, 12'h000, 3'd0, 0, 0);
`ifdef PROG_SEQ_INT_EN
    op_t(3'b001, 1, 12'h03E, 12'h000, 0, 0, 1, 0, 1, 12'h03E, 12'h000, 3'd0, 0, 0);
    op_t(3'b010, 0, 12'h040, 12'h000, 0, 0, 1, 1, 0, 12'h040, 12'h040, 3'd1, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h004, 12'h042, 3'd2, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 1, 0, 12'h006, 12'h042, 3'd2, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h008, 12'h042, 3'd2, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 1, 12'h00A, 12'h042, 3'd2, 0, 0);
    op_t(3'b000, 0, 12'h000, 12'h000, 0, 0, 1, 0, 0, 12'h004, 12'h00C, 3'd3, 0, 0);
`endif
    op = 3'b000; stall = 1'b1; clr_flags = 1'b0; int_req = 1'b0; eint = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Program-address stage directly upstream of instruction memory: owns the 12-bit program counter and the TMS32010-style hardware return stack. Each cycle it selects the next fetch address (sequential, branch, call, return), exposes the registered PC to instruction-memory `addr`, and supplies the stack top that feeds the PC-input and accumulator-input muxes. It also handles PUSH/POP between the accumulator and the stack.

## Interface
- `PC_W`, 12: program address width.
- `PC_STEP`, 2: sequential increment.
- `STACK_DEPTH`, 4: return-stack entries.
- `INT_VECTOR`, 12'h004: interrupt target (with `PROG_SEQ_INT_EN` only).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold all state; `op` is ignored.
- `op`  in  3  sequencer opcode (encodings below).
- `cond`  in  1  branch condition, used by BRANCH only.
- `target`  in  PC_W  branch/call address from instruction or data bus.
- `push_data`  in  PC_W  value for PUSH (accumulator low bits).
- `clr_flags`  in  1  clears the sticky stack flags.
- `int_req`  in  1  interrupt request pulse (`PROG_SEQ_INT_EN` only).
- `eint`, `dint`  in  1 each  interrupt enable / disable (`PROG_SEQ_INT_EN` only).
- `pc`  out  PC_W  registered fetch address.
- `stack_top`  out  PC_W  registered top-of-stack.
- `stack_depth`  out  3  valid entries, 0..STACK_DEPTH.
- `stk_ovf`, `stk_unf`  out  1 each  sticky overflow / underflow.

## Operation
- Opcodes:
  - 000 SEQ
  - 001 BRANCH
  - 010 CALL
  - 011 RET
  - 100 PUSH
  - 101 POP
  - 110/111 reserved, treated as SEQ
- Define seq = `pc + PC_STEP`, computed mod 2^PC_W (4094+2 wraps to 0).
- SEQ: pc <= seq.
- BRANCH: pc <= `cond` ? target : seq.
- CALL: push seq; pc <= target.
- RET: pop; pc <= popped top.
- PUSH: push `push_data`; pc <= seq.
- POP: pop; pc <= seq. The popped value appears on `stack_top` before the pop, so the consumer samples it during the POP cycle.
- `target` bit 0 is forced to 0 whenever `PC_STEP` = 2.
- Stack organisation: shift register.
  - Push: every entry shifts down one and the new value enters the top.
  - Pop: every entry shifts up one; the bottom entry keeps its value (duplicates).
- Push when `stack_depth` = STACK_DEPTH: the oldest entry is lost, depth stays at max, `stk_ovf` <= 1.
- Pop when depth = 0: the shift still happens, pc takes the current top (RET), depth stays 0, `stk_unf` <= 1.
- `stk_ovf` / `stk_unf` are sticky until reset or `clr_flags`. If `clr_flags` arrives in the same cycle as a new error, the set wins.
- Stall: pc, stack, depth, flags and interrupt-enable are held. A pending interrupt is still latched while stalled.

## Timing
- Reset (`reset_n` = 0 at an edge) gives:
  - pc = 0
  - all stack entries = 0, stack_depth = 0
  - stk_ovf = stk_unf = 0
  - interrupt-enable = 0, pending = 0
- Reset overrides every other input, including mid-CALL and under stall.
- Latency: `op` sampled at edge N takes effect on `pc` / `stack_top` / `stack_depth` immediately after edge N. One operation per cycle, no bubbles.
- Instruction memory sees the new `pc` in the cycle after the op. Fetch-side delay is the instruction-memory's own.

## Configuration
- Macro: `PROG_SEQ_INT_EN`.
- Defined:
  - `int_req` sets a pending latch.
  - `eint` sets and `dint` clears the enable flag; `dint` wins if both are high.
  - The interrupt is taken at an unstalled edge where pending && enable && op is SEQ. Taking it pushes seq, sets pc <= INT_VECTOR, clears pending and clears enable.
  - Under any non-SEQ op the interrupt is deferred.
- Undefined: `int_req`/`eint`/`dint` are ignored, no interrupt logic is generated, and `INT_VECTOR` is unused.

## Structure
- Shared package `prog_seq_pkg`: opcode localparams (`OP_SEQ`…`OP_POP`), default `PC_W`, `STACK_DEPTH`, `INT_VECTOR`.
- One sub-module `hw_stack`:
  - Parameterised width/depth.
  - Inputs: push, pop, din.
  - Outputs: top, depth, ovf_evt, unf_evt.
  - Push and pop are never asserted together by the sequencer.
- Sticky flags and PC mux stay in `program_sequencer`.

## Test plan
- Reset then 3× SEQ: pc 0→2→4→6. Stall for 2 cycles holds pc = 6.
- Wrap: BRANCH cond=1 target=12'hFFE, then SEQ: pc = FFE → 000. BRANCH cond=0: pc = seq.
- Call/return: at pc=10, CALL 0x200: pc = 200, stack_top = 012, depth = 1. RET: pc = 012, depth = 0.
- Overflow: 5× PUSH of 1..5: depth = 4, stack_top = 5, stk_ovf = 1. Then 5× POP: the tops read 5, 4, 3, 2, 2, and stk_unf = 1 on the fifth pop. After `clr_flags`, both flags = 0.
- Reset mid-operation: CALL coinciding with `reset_n` = 0 gives pc = 0, depth = 0.
- `PROG_SEQ_INT_EN`:
  - eint, then int_req during a CALL: the interrupt is deferred.
  - At the next SEQ at pc=0x40: pc = 004, stack_top = 042, enable = 0.
  - A second int_req stays pending until eint.
